// File: rtl/lcd_bus_driver.sv
// Purpose: executes 10-bit LCD instruction words as RS/DB setup, E strobe, hold and execution delay on a write-only HD44780-style bus.
// Latency: done POWERUP_CYC cycles after reset release; done N+1+SETUP_CYC+E_HIGH_CYC+HOLD_CYC+wait_cycles for an accept edge in cycle N.
// Backpressure: none; a start edge while busy is dropped and flagged by a one-cycle overrun pulse.
module lcd_bus_driver #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned E_HIGH_CYC  = 12,
  parameter int unsigned HOLD_CYC    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  cmd,
  input  logic [16:0] wait_cycles,
  output logic        done,
  output logic        busy,
  output logic        overrun,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_db
);

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    EHIGH = 3'd3,
    HOLD  = 3'd4,
    WAIT  = 3'd5
  } state_t;

  // Terminal counts: power-up counts up from 0, every other phase counts down to 0.
  localparam logic [19:0] PWR_LAST   = 20'(POWERUP_CYC - 1);
  localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EHIGH_LAST = 20'(E_HIGH_CYC - 1);
  localparam logic [19:0] HOLD_LAST  = 20'(HOLD_CYC - 1);

  state_t      state;
  state_t      state_n;
  logic [19:0] cnt;
  logic [19:0] cnt_n;
  logic        start_q;
  logic        start_edge;
  logic        accept;
  logic [16:0] wait_q;
  logic        done_n;
  logic        lcd_e_n;
  logic        overrun_n;

  // Bit 8 of the instruction word carries no meaning on the bus.
  logic cmd8_unused;
  assign cmd8_unused = cmd[8];

  assign start_edge = start && !start_q;
  assign busy       = (state != IDLE);
  assign lcd_rw     = 1'b0;

  // State and shared phase counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PWRUP;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, counter load/step and next values of the registered strobes.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    case (state)
      PWRUP: begin
        if (cnt == PWR_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 20'd1;
        end
      end
      IDLE: begin
        // An edge in the done cycle itself is accepted: the sequencer chains off done.
        if (start_edge) begin
          accept  = 1'b1;
          state_n = SETUP;
          cnt_n   = SETUP_LAST;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = EHIGH;
          cnt_n   = EHIGH_LAST;
        end else begin
          cnt_n = cnt - 20'd1;
        end
      end
      EHIGH: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LAST;
        end else begin
          cnt_n = cnt - 20'd1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (wait_q == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = WAIT;
            cnt_n   = {3'b000, wait_q} - 20'd1;
          end
        end else begin
          cnt_n = cnt - 20'd1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 20'd1;
        end
      end
      default: begin
        state_n = PWRUP;
        cnt_n   = '0;
      end
    endcase
    done_n    = (state_n == IDLE) && (state != IDLE);
    lcd_e_n   = (state_n == EHIGH);
    overrun_n = start_edge && (state != IDLE);
  end

  // Start edge history and registered, glitch-free status/strobe outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      lcd_e   <= 1'b0;
    end else begin
      start_q <= start;
      done    <= done_n;
      overrun <= overrun_n;
      lcd_e   <= lcd_e_n;
    end
  end

  // Capture RS/DB and the execution delay on accept; the bus holds them until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_rs <= 1'b0;
      lcd_db <= '0;
      wait_q <= '0;
    end else if (accept) begin
      lcd_rs <= cmd[9];
      lcd_db <= cmd[7:0];
      wait_q <= wait_cycles;
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver: randomized and directed start/cmd/wait stimulus against a cycle-window reference model.
// Expected done/overrun cycles are queued at stimulus time and popped by a negedge monitor.
// Bus, strobe and busy levels are checked every cycle against the model's current command windows.
module tb_lcd_bus_driver;

  localparam int P = 10;
  localparam int S = 2;
  localparam int E = 3;
  localparam int H = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_drv = 1'b0;
  logic        init_mode = 1'b0;
  logic        start;
  logic [9:0]  cmd = '0;
  logic [16:0] wait_cycles = '0;
  logic        done;
  logic        busy;
  logic        overrun;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_db;

  lcd_bus_driver #(
    .POWERUP_CYC(P),
    .SETUP_CYC  (S),
    .E_HIGH_CYC (E),
    .HOLD_CYC   (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmd        (cmd),
    .wait_cycles(wait_cycles),
    .done       (done),
    .busy       (busy),
    .overrun    (overrun),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_db     (lcd_db)
  );

  always #5 clk = ~clk;

  // In init mode the sequencer drives start straight from done.
  assign start = init_mode ? done : start_drv;

  // Cycle index since reset release: cycle 0 is the partial cycle in which rst rises.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Reference model state
  int         idle_from;
  int         acc;
  int         e_rise;
  int         e_fall;
  logic       rs_cur, rs_prev;
  logic [7:0] db_cur, db_prev;
  logic       prev_start;
  int         done_q[$];
  int         ovr_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    done_q.delete();
    ovr_q.delete();
    idle_from  = P;
    acc        = -1;
    e_rise     = -1;
    e_fall     = -1;
    rs_cur     = 1'b0;
    rs_prev    = 1'b0;
    db_cur     = '0;
    db_prev    = '0;
    prev_start = 1'b0;
    done_q.push_back(P);
  endtask

  // A rising start edge in cycle c: accepted if the driver is idle by then, else dropped.
  task automatic model_edge(input int c, input logic [9:0] cv, input logic [16:0] w);
    if (c >= idle_from) begin
      acc       = c;
      rs_prev   = rs_cur;
      db_prev   = db_cur;
      rs_cur    = cv[9];
      db_cur    = cv[7:0];
      e_rise    = c + 1 + S;
      e_fall    = e_rise + E;
      idle_from = e_fall + H + int'(w);
      done_q.push_back(idle_from);
    end else begin
      ovr_q.push_back(c + 1);
    end
  endtask

  // Drive one cycle of inputs just after the active edge and feed any start edge to the model.
  task automatic tick(input logic m, input logic s, input logic [9:0] c, input logic [16:0] w);
    logic eff;
    @(posedge clk);
    #1;
    init_mode   = m;
    start_drv   = s;
    cmd         = c;
    wait_cycles = w;
    eff = m ? done : s;
    if (eff && !prev_start) model_edge(cyc, c, w);
    prev_start = eff;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 10'($urandom), 17'($urandom_range(0, 100000)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lcd_e"}, lcd_e, 1'b0);
    check({tag, "_lcd_rs"}, lcd_rs, 1'b0);
    check({tag, "_lcd_db"}, lcd_db, 8'h00);
    check({tag, "_lcd_rw"}, lcd_rw, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  // Monitor: per-cycle bus/strobe/busy levels plus queued done and overrun events.
  always @(negedge clk) begin
    if (rst) begin
      logic exp_done;
      logic exp_ovr;
      check("busy", busy, (cyc < idle_from) && (cyc != acc));
      check("lcd_e", lcd_e, (cyc >= e_rise) && (cyc < e_fall));
      check("lcd_rs", lcd_rs, (cyc > acc) ? rs_cur : rs_prev);
      check("lcd_db", lcd_db, (cyc > acc) ? db_cur : db_prev);
      check("lcd_rw", lcd_rw, 1'b0);
      exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
      check("done", done, exp_done);
      if (exp_done) void'(done_q.pop_front());
      exp_ovr = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
      check("overrun", overrun, exp_ovr);
      if (exp_ovr) void'(ovr_q.pop_front());
    end
  end

  initial begin
    int guard;
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    // Power-up: busy through cycle 9, done only in cycle 10.
    idle(14);

    // Command timing: RS/DB from N+1, E over N+3..N+5, done at N+12; later input changes ignored.
    tick(1'b0, 1'b1, 10'h241, 17'd5);
    idle(16);

    // Zero wait: done at N+7.
    tick(1'b0, 1'b1, 10'h030, 17'd0);
    idle(10);

    // Start during busy: edge at N+4 gives overrun at N+5; start held high through done is not re-accepted.
    tick(1'b0, 1'b1, 10'h1A5, 17'd3);
    repeat (3) tick(1'b0, 1'b0, 10'h000, 17'd0);
    tick(1'b0, 1'b1, 10'h055, 17'd0);
    repeat (15) tick(1'b0, 1'b1, 10'($urandom), 17'($urandom_range(0, 20)));
    idle(4);

    // Long execution delay.
    tick(1'b0, 1'b1, 10'h101, 17'd2000);
    idle(2010);

    // Reset mid-strobe: outputs clear at once, power-up delay restarts.
    tick(1'b0, 1'b1, 10'h2C3, 17'd7);
    guard = 0;
    while (cyc != e_rise + 1 && guard < 20) begin
      tick(1'b0, 1'b0, 10'h000, 17'd0);
      guard++;
    end
    check("pre_reset_lcd_e", lcd_e, (cyc >= e_rise) && (cyc < e_fall));
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    start_drv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Init mode: start tied to done, back-to-back commands chained from the power-up done.
    repeat (120) tick(1'b1, 1'b0, 10'($urandom), 17'($urandom_range(0, 6)));

    // Random traffic with frequent busy-period starts.
    repeat (800) tick(1'b0, ($urandom_range(0, 3) == 0), 10'($urandom), 17'($urandom_range(0, 10)));

    // Drain outstanding expectations.
    guard = 0;
    while ((done_q.size() > 0 || ovr_q.size() > 0) && guard < 5000) begin
      idle(1);
      guard++;
    end
    if (guard >= 5000) check("drain_timeout", done_q.size() + ovr_q.size(), 0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Executes 10-bit LCD instruction words from the instruction sequencer on a write-only HD44780-style parallel bus.
- Generates RS/DB setup, the E strobe and data hold, then waits a per-instruction execution delay.
- Returns a one-cycle `done` pulse, which is the sequencer's `set`/delay_done input.
- After reset it enforces the LCD power-up delay and emits the first `done` that starts the init sequence.

Parameters:
- POWERUP_CYC, 750000: cycles from reset release to first `done` (15 ms at 50 MHz); range 1..2^20-1.
- SETUP_CYC, 2: cycles RS/DB are stable before E rises; ≥1.
- E_HIGH_CYC, 12: cycles E is held high; ≥1.
- HOLD_CYC, 1: cycles RS/DB are held after E falls, before the delay phase; ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command request; rising-edge qualified (the sequencer's start_delay).
- cmd  in  10  instruction; bit9 = RS, bits7:0 = DB, bit8 ignored.
- wait_cycles  in  17  post-strobe execution delay in clk cycles (2000 / 76000 typical).
- done  out  1  one-cycle pulse when the current operation (power-up or command) completes.
- busy  out  1  high while not in IDLE.
- overrun  out  1  one-cycle pulse when a start rising edge is dropped because busy.
- lcd_e  out  1  enable strobe.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  constant 0 (write only).
- lcd_db  out  8  data bus.

Behaviour:
- Reset (rst=0, async):
  - state=PWRUP; lcd_e=0, lcd_rs=0, lcd_db=0, lcd_rw=0.
  - done=0, overrun=0, busy=1; cycle counter=0, start_q=0.
- Edge detect: start_q registers start every cycle. A start edge is start=1 && start_q=0.
- States: PWRUP, IDLE, SETUP, EHIGH, HOLD, WAIT. A single 20-bit down/up counter is shared by all states.
- PWRUP:
  - Counts POWERUP_CYC cycles after reset release.
  - On the last count, goes to IDLE with done=1 for exactly that IDLE-entry cycle; busy=0 in the same cycle.
- IDLE:
  - A start edge (including one coincident with the done cycle, since the sequencer drives start combinationally from done during init) latches lcd_rs=cmd[9], lcd_db=cmd[7:0], and the wait register=wait_cycles.
  - Goes to SETUP; busy=1 from the next cycle.
  - If the accept edge is cycle N: RS/DB are valid from N+1.
- SETUP: SETUP_CYC cycles, E=0.
- EHIGH: lcd_e=1 for exactly E_HIGH_CYC cycles, i.e. cycles N+1+SETUP_CYC .. N+SETUP_CYC+E_HIGH_CYC.
- HOLD: E=0 for HOLD_CYC cycles; RS/DB unchanged.
- WAIT:
  - Lasts wait_cycles cycles.
  - wait_cycles=0 skips WAIT; HOLD goes directly to IDLE.
- Completion:
  - Entering IDLE asserts done for one cycle.
  - Latency: done in cycle N+1+SETUP_CYC+E_HIGH_CYC+HOLD_CYC+W.
- Bus holding: RS/DB keep their last values in IDLE until the next accept.
- Busy-period starts:
  - A start edge in any non-IDLE state is ignored and pulses overrun for one cycle. The current command is unaffected.
  - start held high across completion is not re-accepted; a new rising edge is required.
- Input sampling: cmd and wait_cycles changes after accept have no effect.
- Reset mid-operation: all outputs return to reset values immediately; E never stays high. The full POWERUP delay restarts on release.
- Counters never wrap. Each state loads its terminal count on entry.

Test Plan:
- Power-up (POWERUP=10, SETUP=2, E_HIGH=3, HOLD=1):
  - Release rst at cycle 0 → busy=1 and done=0 for cycles 0..9.
  - done=1 only in cycle 10; busy=0 from cycle 10.
- Command timing:
  - Start edge at cycle N with cmd=10'h241, wait=5 → lcd_rs=1, lcd_db=8'h41 from N+1.
  - lcd_e=1 exactly for N+3..N+5; done=1 exactly at N+12.
- Zero wait: cmd=10'h030, wait=0 → rs=0, db=8'h30, done at N+7, no WAIT cycles.
- Coincident start and done: start tied to done (sequencer init mode) → back-to-back commands with exactly one IDLE cycle between them and no lost command.
- Start during busy: a second start edge at N+4 → overrun=1 at N+5 only; the first command completes normally; a start held high through done is not re-accepted.
- Reset mid-strobe: assert rst while lcd_e=1 → lcd_e/lcd_rs/lcd_db=0 immediately; after release, done reappears only after 10 cycles.
